// File: rtl/act_mem_access_arbiter.sv
// act_mem_access_arbiter: fixed-priority N-source arbiter for the activation memory with TCN ring encoding, tagged read return and mirror FIFO; ACT_ARB_RAW_FWD_EN adds same-cycle RAW forwarding
module act_mem_access_arbiter #(
    parameter int N_SRC          = 3,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 8,
    parameter int N_LANES        = 16,
    parameter int RD_LATENCY     = 1,
    parameter int OUT_FIFO_DEPTH = 4,
    localparam int SRC_W         = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    localparam int W             = N_LANES * DATA_W
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [N_SRC-1:0]        src_rd_en_i,
    input  logic [N_SRC*ADDR_W-1:0] src_rd_addr_i,
    input  logic [N_SRC-1:0]        src_wr_en_i,
    input  logic [N_SRC*ADDR_W-1:0] src_wr_addr_i,
    input  logic [N_SRC*W-1:0]      src_wr_data_i,
    output logic [N_SRC-1:0]        src_rd_gnt_o,
    output logic [N_SRC-1:0]        src_wr_gnt_o,
    input  logic                    fifo_tcn_active_i,
    input  logic [ADDR_W-1:0]       fifo_tcn_block_size_i,
    input  logic [ADDR_W-1:0]       fifo_tcn_total_blocks_i,
    input  logic [ADDR_W-1:0]       fifo_tcn_offset_i,
    input  logic                    fifo_tcn_update_pointer_i,
    output logic                    mem_rd_en_o,
    output logic [ADDR_W-1:0]       mem_rd_addr_o,
    output logic                    mem_wr_en_o,
    output logic [ADDR_W-1:0]       mem_wr_addr_o,
    output logic [W-1:0]            mem_wr_data_o,
    input  logic [W-1:0]            mem_rd_data_i,
    output logic                    rd_valid_o,
    output logic [SRC_W-1:0]        rd_src_o,
    output logic [W-1:0]            rd_data_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [31:0]             out_addr_o,
    output logic [W-1:0]            out_data_o,
    output logic                    out_overflow_o
);
    localparam int PTR_W = $clog2(OUT_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic [ADDR_W-1:0] tcn_enc(input logic [ADDR_W-1:0] a, input logic act,
                                                  input logic [ADDR_W-1:0] off, input logic [ADDR_W:0] ring,
                                                  input logic [ADDR_W:0] base);
        logic [ADDR_W:0] rel;
        logic [ADDR_W:0] phys;
        rel = {1'b0, a} - {1'b0, off} + base;
        if (rel >= ring) rel = rel - ring;
        phys = {1'b0, off} + rel;
        return (act && ring != '0 && a >= off && {1'b0, a} < {1'b0, off} + ring) ? phys[ADDR_W-1:0] : a;
    endfunction

    logic [ADDR_W-1:0] rd_addr_sel, wr_addr_sel, mem_rd_addr_d, mem_wr_addr_d;
    logic [W-1:0]      wr_data_sel;
    logic [SRC_W-1:0]  rd_src_sel;
    logic [ADDR_W:0]   ring, base_sum, base_d, base_q;
    logic              mem_rd_en_q, mem_wr_en_q;
    logic [ADDR_W-1:0] mem_rd_addr_q, mem_wr_addr_q;
    logic [W-1:0]      mem_wr_data_q;
    logic [SRC_W-1:0]  mem_rd_src_q;

    assign src_rd_gnt_o = src_rd_en_i & (~src_rd_en_i + N_SRC'(1));
    assign src_wr_gnt_o = src_wr_en_i & (~src_wr_en_i + N_SRC'(1));

    // winner mux, ring base advance and physical address encoding
    always_comb begin
        rd_addr_sel = '0;
        wr_addr_sel = '0;
        wr_data_sel = '0;
        rd_src_sel  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (src_rd_gnt_o[i]) begin
                rd_addr_sel = src_rd_addr_i[i*ADDR_W +: ADDR_W];
                rd_src_sel  = SRC_W'(i);
            end
            if (src_wr_gnt_o[i]) begin
                wr_addr_sel = src_wr_addr_i[i*ADDR_W +: ADDR_W];
                wr_data_sel = src_wr_data_i[i*W +: W];
            end
        end
        ring          = {1'b0, fifo_tcn_block_size_i} * {1'b0, fifo_tcn_total_blocks_i};
        base_sum      = base_q + {1'b0, fifo_tcn_block_size_i};
        base_d        = fifo_tcn_update_pointer_i ? ((base_sum >= ring) ? '0 : base_sum) : base_q;
        mem_rd_addr_d = tcn_enc(rd_addr_sel, fifo_tcn_active_i, fifo_tcn_offset_i, ring, base_q);
        mem_wr_addr_d = tcn_enc(wr_addr_sel, fifo_tcn_active_i, fifo_tcn_offset_i, ring, base_q);
    end

    // registered memory request ports and ring base pointer
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            mem_rd_src_q  <= '0;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            base_q        <= '0;
        end else begin
            mem_rd_en_q   <= |src_rd_gnt_o;
            mem_rd_addr_q <= mem_rd_addr_d;
            mem_rd_src_q  <= rd_src_sel;
            mem_wr_en_q   <= |src_wr_gnt_o;
            mem_wr_addr_q <= mem_wr_addr_d;
            mem_wr_data_q <= wr_data_sel;
            base_q        <= base_d;
        end
    end

    assign mem_rd_en_o   = mem_rd_en_q;
    assign mem_rd_addr_o = mem_rd_addr_q;
    assign mem_wr_en_o   = mem_wr_en_q;
    assign mem_wr_addr_o = mem_wr_addr_q;
    assign mem_wr_data_o = mem_wr_data_q;

    logic [RD_LATENCY-1:0] vld_q;
    logic [SRC_W-1:0]      tag_q [RD_LATENCY];

    // valid/tag shift register tracking reads through the memory latency
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) tag_q[i] <= '0;
        end else begin
            vld_q[0] <= mem_rd_en_q;
            tag_q[0] <= mem_rd_src_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign rd_valid_o = vld_q[RD_LATENCY-1];
    assign rd_src_o   = vld_q[RD_LATENCY-1] ? tag_q[RD_LATENCY-1] : '0;

`ifdef ACT_ARB_RAW_FWD_EN
    logic [RD_LATENCY-1:0] fwd_q;
    logic [W-1:0]          fwd_data_q [RD_LATENCY];

    // carry same-address write data alongside the read so it replaces the memory word
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            fwd_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) fwd_data_q[i] <= '0;
        end else begin
            fwd_q[0]      <= mem_rd_en_q && mem_wr_en_q && (mem_rd_addr_q == mem_wr_addr_q);
            fwd_data_q[0] <= mem_wr_data_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                fwd_q[i]      <= fwd_q[i-1];
                fwd_data_q[i] <= fwd_data_q[i-1];
            end
        end
    end

    assign rd_data_o = !vld_q[RD_LATENCY-1] ? '0 :
                       fwd_q[RD_LATENCY-1] ? fwd_data_q[RD_LATENCY-1] : mem_rd_data_i;
`else
    assign rd_data_o = vld_q[RD_LATENCY-1] ? mem_rd_data_i : '0;
`endif

    logic [ADDR_W+W-1:0] fifo_q [OUT_FIFO_DEPTH];
    logic [ADDR_W+W-1:0] head;
    logic [PTR_W-1:0]    wp_q, rp_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q, full, empty, pop, push_ok;

    assign full    = cnt_q == CNT_W'(OUT_FIFO_DEPTH);
    assign empty   = cnt_q == '0;
    assign pop     = !empty && out_ready_i;
    assign push_ok = mem_wr_en_q && (!full || pop);
    assign head    = fifo_q[rp_q];

    // mirror FIFO of issued writes; a push into a full FIFO without a pop is dropped and flagged
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push_ok) begin
                fifo_q[wp_q] <= {mem_wr_addr_q, mem_wr_data_q};
                wp_q         <= wp_q + PTR_W'(1);
            end
            if (pop) rp_q <= rp_q + PTR_W'(1);
            cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop);
            if (mem_wr_en_q && !push_ok) ovf_q <= 1'b1;
        end
    end

    assign out_valid_o    = !empty;
    assign out_addr_o     = empty ? '0 : 32'(head[ADDR_W+W-1 -: ADDR_W]);
    assign out_data_o     = empty ? '0 : head[W-1:0];
    assign out_overflow_o = ovf_q;
endmodule

// File: tb/tb_act_mem_access_arbiter.sv
// tb_act_mem_access_arbiter: table-driven arbitration vectors plus directed TCN, FIFO, reset and RAW sequences
module tb_act_mem_access_arbiter;
    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   rd_en, wr_en, rd_gnt, wr_gnt;
    logic [47:0]  rd_addr, wr_addr;
    logic [383:0] wr_data;
    logic         tcn_act, tcn_upd;
    logic [15:0]  tcn_blk, tcn_tot, tcn_off;
    logic         mem_rd_en, mem_wr_en, rd_valid, out_valid, out_ready, out_overflow;
    logic [15:0]  mem_rd_addr, mem_wr_addr;
    logic [127:0] mem_wr_data, mem_rd_data, rd_data, out_data;
    logic [1:0]   rd_src;
    logic [31:0]  out_addr;
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    act_mem_access_arbiter dut (
        .clk_i(clk), .reset_i(reset),
        .src_rd_en_i(rd_en), .src_rd_addr_i(rd_addr),
        .src_wr_en_i(wr_en), .src_wr_addr_i(wr_addr), .src_wr_data_i(wr_data),
        .src_rd_gnt_o(rd_gnt), .src_wr_gnt_o(wr_gnt),
        .fifo_tcn_active_i(tcn_act), .fifo_tcn_block_size_i(tcn_blk),
        .fifo_tcn_total_blocks_i(tcn_tot), .fifo_tcn_offset_i(tcn_off),
        .fifo_tcn_update_pointer_i(tcn_upd),
        .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr),
        .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
        .mem_rd_data_i(mem_rd_data),
        .rd_valid_o(rd_valid), .rd_src_o(rd_src), .rd_data_o(rd_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_addr_o(out_addr), .out_data_o(out_data), .out_overflow_o(out_overflow)
    );

    function automatic logic [127:0] f(input logic [15:0] a);
        return {8{a ^ 16'h5A5A}};
    endfunction

    function automatic logic [127:0] sdat(input logic [1:0] s);
        return (s == 2'd0) ? {16{8'h11}} : (s == 2'd1) ? {16{8'h22}} : {16{8'h33}};
    endfunction

    // memory model with one cycle read latency
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= f(mem_rd_addr);

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a, input logic [15:0] exp);
        rd_en = 3'b001;
        rd_addr[15:0] = a;
        step();
        rd_en = 3'b000;
        check({nm, " en"}, 128'(mem_rd_en), 128'(1'b1));
        check({nm, " addr"}, 128'(mem_rd_addr), 128'(exp));
    endtask

    typedef struct {
        logic [2:0]  rd_en;
        logic [47:0] ra;
        logic [2:0]  wr_en;
        logic [47:0] wa;
        logic [2:0]  e_rg;
        logic [2:0]  e_wg;
        logic        e_mrd;
        logic [15:0] e_mra;
        logic        e_mwr;
        logic [15:0] e_mwa;
        logic [1:0]  e_ws;
        logic        e_rv;
        logic [1:0]  e_rs;
        logic [15:0] e_ra;
    } vec_t;

    vec_t tv [8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        tv[0] = '{3'b101, {16'h20, 16'h0, 16'h10}, 3'b000, 48'h0, 3'b001, 3'b000, 1'b1, 16'h10, 1'b0, 16'h0, 2'd0, 1'b0, 2'd0, 16'h0};
        tv[1] = '{3'b100, {16'h20, 16'h0, 16'h0}, 3'b000, 48'h0, 3'b100, 3'b000, 1'b1, 16'h20, 1'b0, 16'h0, 2'd0, 1'b1, 2'd0, 16'h10};
        tv[2] = '{3'b000, 48'h0, 3'b110, {16'h40, 16'h30, 16'h0}, 3'b000, 3'b010, 1'b0, 16'h0, 1'b1, 16'h30, 2'd1, 1'b1, 2'd2, 16'h20};
        tv[3] = '{3'b010, {16'h0, 16'h55, 16'h0}, 3'b100, {16'h40, 16'h0, 16'h0}, 3'b010, 3'b100, 1'b1, 16'h55, 1'b1, 16'h40, 2'd2, 1'b0, 2'd0, 16'h0};
        tv[4] = '{3'b111, {16'h3, 16'h2, 16'h1}, 3'b111, {16'h9, 16'h8, 16'h7}, 3'b001, 3'b001, 1'b1, 16'h1, 1'b1, 16'h7, 2'd0, 1'b1, 2'd1, 16'h55};
        tv[5] = '{3'b110, {16'h3, 16'h2, 16'h0}, 3'b000, 48'h0, 3'b010, 3'b000, 1'b1, 16'h2, 1'b0, 16'h0, 2'd0, 1'b1, 2'd0, 16'h1};
        tv[6] = '{3'b000, 48'h0, 3'b000, 48'h0, 3'b000, 3'b000, 1'b0, 16'h0, 1'b0, 16'h0, 2'd0, 1'b1, 2'd1, 16'h2};
        tv[7] = '{3'b000, 48'h0, 3'b000, 48'h0, 3'b000, 3'b000, 1'b0, 16'h0, 1'b0, 16'h0, 2'd0, 1'b0, 2'd0, 16'h0};

        reset = 1'b1; rd_en = '0; wr_en = '0; rd_addr = '0; wr_addr = '0;
        wr_data = {sdat(2), sdat(1), sdat(0)};
        tcn_act = 1'b0; tcn_upd = 1'b0; tcn_blk = 16'd8; tcn_tot = 16'd4; tcn_off = 16'h100;
        out_ready = 1'b1; mem_rd_data = '0;
        repeat (3) step();
        reset = 1'b0;
        check("reset mem_rd_en", 128'(mem_rd_en), 128'(1'b0));
        check("reset mem_wr_en", 128'(mem_wr_en), 128'(1'b0));
        check("reset rd_valid", 128'(rd_valid), 128'(1'b0));
        check("reset rd_data", rd_data, 128'h0);
        check("reset out_valid", 128'(out_valid), 128'(1'b0));
        check("reset out_overflow", 128'(out_overflow), 128'(1'b0));

        // arbitration table, encoding disabled
        for (int k = 0; k < 8; k++) begin
            rd_en = tv[k].rd_en; rd_addr = tv[k].ra; wr_en = tv[k].wr_en; wr_addr = tv[k].wa;
            #1;
            check($sformatf("v%0d rd_gnt", k), 128'(rd_gnt), 128'(tv[k].e_rg));
            check($sformatf("v%0d wr_gnt", k), 128'(wr_gnt), 128'(tv[k].e_wg));
            step();
            check($sformatf("v%0d mem_rd_en", k), 128'(mem_rd_en), 128'(tv[k].e_mrd));
            if (tv[k].e_mrd) check($sformatf("v%0d mem_rd_addr", k), 128'(mem_rd_addr), 128'(tv[k].e_mra));
            check($sformatf("v%0d mem_wr_en", k), 128'(mem_wr_en), 128'(tv[k].e_mwr));
            if (tv[k].e_mwr) begin
                check($sformatf("v%0d mem_wr_addr", k), 128'(mem_wr_addr), 128'(tv[k].e_mwa));
                check($sformatf("v%0d mem_wr_data", k), mem_wr_data, sdat(tv[k].e_ws));
            end
            check($sformatf("v%0d rd_valid", k), 128'(rd_valid), 128'(tv[k].e_rv));
            if (tv[k].e_rv) begin
                check($sformatf("v%0d rd_src", k), 128'(rd_src), 128'(tv[k].e_rs));
                check($sformatf("v%0d rd_data", k), rd_data, f(tv[k].e_ra));
            end
        end
        rd_addr = '0; wr_addr = '0;

        // TCN ring: offset 0x100, 4 blocks of 8
        tcn_act = 1'b1;
        repeat (3) begin
            tcn_upd = 1'b1;
            step();
        end
        tcn_upd = 1'b0;
        rd_chk("tcn base24 0x100", 16'h100, 16'h118);
        rd_chk("tcn base24 0x10F wrap", 16'h10F, 16'h107);
        rd_chk("tcn ring end 0x120", 16'h120, 16'h120);
        rd_chk("tcn below 0x0FF", 16'h0FF, 16'h0FF);
        tcn_upd = 1'b1;
        step();
        tcn_upd = 1'b0;
        rd_chk("tcn wrap base0 0x100", 16'h100, 16'h100);

        // update coincident with a write uses the old base
        tcn_upd = 1'b1;
        step();
        wr_en = 3'b001; wr_addr[15:0] = 16'h101;
        step();
        tcn_upd = 1'b0;
        check("upd+wr addr", 128'(mem_wr_addr), 128'(16'h109));
        step();
        wr_en = 3'b000;
        check("after upd addr", 128'(mem_wr_addr), 128'(16'h111));

        // overflow of the mirror FIFO
        tcn_act = 1'b0;
        repeat (3) step();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            b = 8'hC0 + 8'(i);
            wr_en = 3'b001; wr_addr[15:0] = 16'h200 + 16'(i); wr_data[127:0] = {16{b}};
            step();
        end
        wr_en = 3'b000;
        repeat (2) step();
        check("fifo full out_valid", 128'(out_valid), 128'(1'b1));
        check("fifo overflow set", 128'(out_overflow), 128'(1'b1));
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b = 8'hC0 + 8'(i);
            check($sformatf("pop%0d valid", i), 128'(out_valid), 128'(1'b1));
            check($sformatf("pop%0d addr", i), 128'(out_addr), 128'(32'h200 + 32'(i)));
            check($sformatf("pop%0d data", i), out_data, {16{b}});
            step();
        end
        check("fifo drained", 128'(out_valid), 128'(1'b0));
        check("overflow sticky", 128'(out_overflow), 128'(1'b1));
        wr_data[127:0] = sdat(0);

        // reset with reads in flight, nonzero base and a queued mirror entry
        tcn_act = 1'b1;
        tcn_upd = 1'b1;
        step();
        tcn_upd = 1'b0;
        out_ready = 1'b0;
        wr_en = 3'b001; wr_addr[15:0] = 16'h300;
        step();
        wr_en = 3'b000;
        repeat (2) step();
        check("pre-reset out_valid", 128'(out_valid), 128'(1'b1));
        rd_en = 3'b001; rd_addr = {16'h0, 16'h11, 16'h10};
        step();
        rd_en = 3'b010;
        reset = 1'b1;
        step();
        rd_en = 3'b000;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("post-reset rd_valid c%0d", i), 128'(rd_valid), 128'(1'b0));
            step();
        end
        check("post-reset out_valid", 128'(out_valid), 128'(1'b0));
        check("post-reset out_overflow", 128'(out_overflow), 128'(1'b0));
        rd_chk("post-reset base0", 16'h100, 16'h100);
        out_ready = 1'b1;

        // same-cycle read/write of one address
        tcn_act = 1'b0;
        wr_data[255:128] = {16{8'hA5}};
        rd_en = 3'b001; rd_addr = {16'h0, 16'h0, 16'h42};
        wr_en = 3'b010; wr_addr = {16'h0, 16'h42, 16'h0};
        step();
        rd_en = 3'b000; wr_en = 3'b000;
        check("raw mem_rd_en", 128'(mem_rd_en), 128'(1'b1));
        check("raw mem_wr_en", 128'(mem_wr_en), 128'(1'b1));
        step();
        check("raw rd_valid", 128'(rd_valid), 128'(1'b1));
        check("raw rd_src", 128'(rd_src), 128'(2'd0));
`ifdef ACT_ARB_RAW_FWD_EN
        check("raw rd_data", rd_data, {16{8'hA5}});
`else
        check("raw rd_data", rd_data, f(16'h42));
`endif
        step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
